// File: rtl/cpu_defs.sv
// Definitions shared by the fetch unit and control_unit: instruction field
// positions, opcode encodings, fetch FSM states and next-PC selector codes.
package cpu_defs;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_INSTR_W = 16;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 11;
  localparam int FLAG_BIT = 10;
  localparam int IMM_MSB  = 9;

  localparam logic [15:0] DEF_RESET_PC = 16'h0000;

  // Opcode 0 with flagbit 0 is APUT, which is also what a cleared IR decodes to.
  localparam logic [4:0] OP_APUT = 5'h00;
  localparam logic [4:0] OP_HALT = 5'h1F;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_SEL_HOLD     = 2'd0,
    PC_SEL_SEQ      = 2'd1,
    PC_SEL_REDIRECT = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select: hold, sequential (PC+2, wrapping) or a
// halfword-aligned redirect. Also exports PC+2 for return-address saves.
module pc_next_mux
  import cpu_defs::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic [1:0]        i_sel,
  output logic [ADDR_W-1:0] o_next_pc,
  output logic [ADDR_W-1:0] o_pc_plus2
);

  logic [ADDR_W-1:0] w_pc_plus2;
  logic [ADDR_W-1:0] w_target_aligned;

  // Sequential increment and aligned redirect candidates; the add wraps naturally.
  always_comb begin
    w_pc_plus2       = i_pc + {{(ADDR_W-2){1'b0}}, 2'b10};
    w_target_aligned = {i_branch_target[ADDR_W-1:1], 1'b0};
  end

  // Select between the candidates.
  always_comb begin
    o_next_pc = i_pc;
    case (i_sel)
      PC_SEL_HOLD:     o_next_pc = i_pc;
      PC_SEL_SEQ:      o_next_pc = w_pc_plus2;
      PC_SEL_REDIRECT: o_next_pc = w_target_aligned;
      default:         o_next_pc = i_pc;
    endcase
  end

  assign o_pc_plus2 = w_pc_plus2;

endmodule

// File: rtl/instr_fetch_unit.sv
// Front end of the multicycle datapath: PC, instruction fetch over a
// req/ready handshake, instruction register, and the BOOT/FETCH/ISSUE/HALT FSM.
module instr_fetch_unit
  import cpu_defs::*;
#(
  parameter int              ADDR_W   = DEF_ADDR_W,
  parameter int              INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [4:0]      HALT_OP  = OP_HALT
) (
  input  logic               CLK,
  input  logic               Reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               stall,
  input  logic               PCWrite,
  input  logic               PCSrc,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [4:0]         OPCODE,
  output logic               flagbit,
  output logic [9:0]         IMM,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  PC,
  output logic [ADDR_W-1:0]  PC_plus2,
  output logic               halted
);

  fetch_state_t       r_state;
  fetch_state_t       w_state_next;
  pc_sel_t            w_pc_sel;
  logic               w_ir_load;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_next;
  logic [ADDR_W-1:0]  w_pc_plus2;
  logic [INSTR_W-1:0] r_ir;
  logic [4:0]         w_opcode;

  assign w_opcode = r_ir[OP_MSB:OP_LSB];

  // FSM state register.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, IR load strobe and next-PC selection.
  always_comb begin
    w_state_next = r_state;
    w_pc_sel     = PC_SEL_HOLD;
    w_ir_load    = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ready) begin
          w_ir_load    = 1'b1;
          w_state_next = ST_ISSUE;
        end else begin
          w_state_next = ST_FETCH;
        end
      end
      ST_ISSUE: begin
        // A stalled issue ignores PCWrite/PCSrc entirely.
        if (stall) begin
          w_state_next = ST_ISSUE;
        end else if (w_opcode == HALT_OP) begin
          w_state_next = ST_HALT;
        end else begin
          w_state_next = ST_FETCH;
          if (PCWrite && PCSrc) begin
            w_pc_sel = PC_SEL_REDIRECT;
          end else begin
            w_pc_sel = PC_SEL_SEQ;
          end
        end
      end
      ST_HALT: begin
        w_state_next = ST_HALT;
      end
      default: begin
        w_state_next = ST_BOOT;
      end
    endcase
  end

  pc_next_mux #(
    .ADDR_W (ADDR_W)
  ) u_pc_next_mux (
    .i_pc            (r_pc),
    .i_branch_target (branch_target),
    .i_sel           (w_pc_sel),
    .o_next_pc       (w_pc_next),
    .o_pc_plus2      (w_pc_plus2)
  );

  // PC and instruction register.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_pc <= RESET_PC;
      r_ir <= {INSTR_W{1'b0}};
    end else begin
      r_pc <= w_pc_next;
      if (w_ir_load) begin
        r_ir <= mem_rdata;
      end
    end
  end

  // Outputs come straight from flops, so mem_req falls as soon as Reset rises.
  assign mem_req     = (r_state == ST_FETCH);
  assign mem_addr    = r_pc;
  assign instr_valid = (r_state == ST_ISSUE);
  assign halted      = (r_state == ST_HALT);
  assign PC          = r_pc;
  assign PC_plus2    = w_pc_plus2;
  assign OPCODE      = w_opcode;
  assign flagbit     = r_ir[FLAG_BIT];
  assign IMM         = r_ir[IMM_MSB:0];

endmodule
